// File: rtl/inv_shift_rows_serial_if.sv
// inv_shift_rows_serial_if: byte-stream bus for the InvShiftRows stage (fwd exists only with INV_SHIFT_ROWS_FWD_EN)
interface inv_shift_rows_serial_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
`ifdef INV_SHIFT_ROWS_FWD_EN
  logic       fwd;
  modport master (output s_valid, s_data, m_ready, fwd, input s_ready, m_valid, m_data, m_last);
  modport slave  (input s_valid, s_data, m_ready, fwd, output s_ready, m_valid, m_data, m_last);
`else
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
  modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
`endif
endinterface

// File: rtl/inv_shift_rows_serial.sv
// inv_shift_rows_serial: byte-serial ping-pong InvShiftRows buffer; INV_SHIFT_ROWS_FWD_EN adds a per-block forward-map select
module inv_shift_rows_serial #(
  parameter int NBANK = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  inv_shift_rows_serial_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;
  bank_st_e   st_q [2];
  bank_st_e   st_d [2];
  logic [7:0] mem_q [2][16];
  logic [3:0] wr_cnt_q, rd_cnt_q, src;
  logic       wr_bank_q, rd_bank_q, wr_en, rd_en;
  logic [1:0] full;
`ifdef INV_SHIFT_ROWS_FWD_EN
  logic [1:0] fwd_q;
`endif
  // Full covers both FULL and DRAINING; the read address is the only place the permutation lives
  always_comb begin
    for (int b = 0; b < 2; b++) full[b] = (st_q[b] == FULL) || (st_q[b] == DRAINING);
`ifdef INV_SHIFT_ROWS_FWD_EN
    src = fwd_q[rd_bank_q] ? 4'(rd_cnt_q * 4'd5) : 4'(rd_cnt_q * 4'd13);
`else
    src = 4'(rd_cnt_q * 4'd13);
`endif
  end
  assign bus.s_ready = !full[wr_bank_q] && rst_n;
  assign bus.m_valid = full[rd_bank_q];
  assign bus.m_data  = mem_q[rd_bank_q][src];
  assign bus.m_last  = bus.m_valid && (rd_cnt_q == 4'd15);
  assign wr_en       = bus.s_valid && bus.s_ready;
  assign rd_en       = bus.m_valid && bus.m_ready;
  // Per-bank lifecycle; a bank is never written and read in the same cycle
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (wr_en && wr_bank_q == 1'(b)) st_d[b] = (wr_cnt_q == 4'd15) ? FULL : FILLING;
      if (rd_en && rd_bank_q == 1'(b)) st_d[b] = (rd_cnt_q == 4'd15) ? EMPTY : DRAINING;
    end
  end
  // Storage, counters and bank pointers; reset wipes contents and any partial block
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
`ifdef INV_SHIFT_ROWS_FWD_EN
      fwd_q     <= '0;
`endif
      for (int b = 0; b < 2; b++) begin
        st_q[b] <= EMPTY;
        for (int i = 0; i < 16; i++) mem_q[b][i] <= 8'h00;
      end
    end else begin
      st_q <= st_d;
      if (wr_en) begin
        mem_q[wr_bank_q][wr_cnt_q] <= bus.s_data;
        wr_cnt_q <= wr_cnt_q + 4'd1;
`ifdef INV_SHIFT_ROWS_FWD_EN
        if (wr_cnt_q == 4'd0) fwd_q[wr_bank_q] <= bus.fwd;
`endif
        if (wr_cnt_q == 4'd15) wr_bank_q <= (NBANK == 2) ? ~wr_bank_q : 1'b0;
      end
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + 4'd1;
        if (rd_cnt_q == 4'd15) rd_bank_q <= (NBANK == 2) ? ~rd_bank_q : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// tb_inv_shift_rows_serial: directed bench for both bank counts of inv_shift_rows_serial
module tb_inv_shift_rows_serial;
  logic       clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic       s_valid = 1'b0, m_ready = 1'b0, fwd = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       sr, mv, ml;
  logic [7:0] md;
  int         total = 0, passed = 0, failed = 0;
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  int         last_acc, first_vld, first_out, last_out, nout, drops, first_drop;

  localparam logic [127:0] T_IN  = 128'h01020304_05060708_09101112_13141516;
  localparam logic [127:0] T_INV = 128'h01141108_05021512_09060316_13100704;
  localparam logic [127:0] T_FWD = 128'h01061116_05101504_09140308_13020712;
  localparam logic [127:0] A_IN  = 128'h49ded289_45db96f1_7f39871a_7702533b;
  localparam logic [127:0] A_INV = 128'h490287f1_45de531a_7fdbd23b_77399689;
  localparam logic [127:0] B_IN  = 128'hac73cf7b_efc111df_13b5d6b5_45235ab8;
  localparam logic [127:0] B_INV = 128'hac23d6df_ef735ab5_13c1cfb8_45b5117b;

  always #5 clk = ~clk;

  inv_shift_rows_serial_if b2();
  inv_shift_rows_serial_if b1();
  assign b2.s_valid = s_valid && !sel;
  assign b1.s_valid = s_valid && sel;
  assign b2.s_data  = s_data;
  assign b1.s_data  = s_data;
  assign b2.m_ready = m_ready && !sel;
  assign b1.m_ready = m_ready && sel;
`ifdef INV_SHIFT_ROWS_FWD_EN
  assign b2.fwd = fwd;
  assign b1.fwd = fwd;
`endif
  inv_shift_rows_serial dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  inv_shift_rows_serial #(.NBANK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  assign sr = sel ? b1.s_ready : b2.s_ready;
  assign mv = sel ? b1.m_valid : b2.m_valid;
  assign ml = sel ? b1.m_last  : b2.m_last;
  assign md = sel ? b1.m_data  : b2.m_data;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push_in(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) in_q.push_back(blk[127-8*i -: 8]);
  endtask

  task automatic push_exp(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) exp_q.push_back(blk[127-8*i -: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", sr, 0);
    chk("rst_m_valid", mv, 0);
    chk("rst_m_last", ml, 0);
    chk("rst_m_data", md, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_s_ready", sr, 1);
    chk("post_rst_m_valid", mv, 0);
    chk("post_rst_m_data", md, 0);
  endtask

  // Runs ncyc cycles, feeding in_q and checking every output transfer against exp_q
  task automatic stream(input int ncyc, input int stall_from, input int stall_len);
    last_acc = -1; first_vld = -1; first_out = -1; last_out = -1;
    nout = 0; drops = 0; first_drop = -1;
    for (int c = 0; c < ncyc; c++) begin
      s_valid = in_q.size() > 0;
      s_data  = s_valid ? in_q[0] : 8'h00;
      m_ready = !(c >= stall_from && c < stall_from + stall_len);
      #1;
      if (s_valid && !sr) begin
        drops++;
        if (first_drop < 0) first_drop = c;
      end
      if (s_valid && sr) begin
        void'(in_q.pop_front());
        last_acc = c;
      end
      if (mv && first_vld < 0) first_vld = c;
      if (mv && !m_ready) begin
        if (exp_q.size() > 0) chk("stall_data", md, exp_q[0]);
      end
      if (mv && m_ready) begin
        if (exp_q.size() == 0) chk("extra_out", mv, 0);
        else begin
          chk($sformatf("data%0d", nout), md, exp_q.pop_front());
          chk($sformatf("last%0d", nout), ml, (nout % 16) == 15);
        end
        if (first_out < 0) first_out = c;
        last_out = c;
        nout++;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("inputs_consumed", in_q.size(), 0);
    chk("outputs_drained", exp_q.size(), 0);
  endtask

  initial begin
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    push_in(T_IN); push_exp(T_INV);
    stream(40, 1000, 0);
    chk("single_latency", first_vld - last_acc, 1);
    chk("single_nout", nout, 16);

    push_in(A_IN); push_in(B_IN); push_exp(A_INV); push_exp(B_INV);
    stream(60, 1000, 0);
    chk("b2b_nout", nout, 32);
    chk("b2b_consecutive", last_out - first_out, 31);
    chk("b2b_no_drop", drops, 0);

    push_in(T_IN); push_in(A_IN); push_in(B_IN);
    push_exp(T_INV); push_exp(A_INV); push_exp(B_INV);
    stream(120, 20, 20);
    chk("bp_nout", nout, 48);
    chk("bp_ready_dropped", drops > 0, 1);
    chk("bp_first_drop", first_drop, 32);

    sel = 1'b1;
    do_reset();
    push_in(A_IN); push_in(B_IN); push_exp(A_INV); push_exp(B_INV);
    stream(80, 1000, 0);
    chk("nb1_nout", nout, 32);
    chk("nb1_first_drop", first_drop, 16);
    chk("nb1_drops", drops, 16);

    sel = 1'b0;
    do_reset();
    push_in(A_IN);
    in_q = in_q[0:6];
    stream(10, 1000, 0);
    chk("partial_no_out", nout, 0);
    do_reset();
    push_in(T_IN); push_exp(T_INV);
    stream(40, 1000, 0);
    chk("after_rst_nout", nout, 16);

`ifdef INV_SHIFT_ROWS_FWD_EN
    fwd = 1'b1;
    push_in(T_IN); push_exp(T_FWD);
    stream(40, 1000, 0);
    chk("fwd_nout", nout, 16);
    fwd = 1'b0;
    push_in(T_IN); push_exp(T_INV);
    stream(40, 1000, 0);
    chk("inv_after_fwd_nout", nout, 16);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
